// File: rtl/mips_pkg.sv
// Shared encodings for the MIPS core: mul/div opcodes
// and the multiply/divide unit FSM states.
package mips_pkg;

  localparam logic [1:0] OP_MULTU = 2'b00;
  localparam logic [1:0] OP_MULT  = 2'b01;
  localparam logic [1:0] OP_DIVU  = 2'b10;
  localparam logic [1:0] OP_DIV   = 2'b11;

  localparam logic [1:0] ST_IDLE = 2'd0;
  localparam logic [1:0] ST_CALC = 2'd1;
  localparam logic [1:0] ST_FIX  = 2'd2;

  function automatic logic op_is_signed(
    input logic [1:0] op
  );
    return op[0];
  endfunction

  function automatic logic op_is_div(
    input logic [1:0] op
  );
    return op[1];
  endfunction

endpackage

// File: rtl/cond_negate.sv
// Conditional two's-complement negate: y = sel ? -x : x.
// Used for operand magnitudes and result sign fix.
module cond_negate #(
  parameter int WIDTH = 32
) (
  input  logic             sel,
  input  logic [WIDTH-1:0] x,
  output logic [WIDTH-1:0] y
);

  assign y = sel ? (~x + WIDTH'(1)) : x;

endmodule

// File: rtl/mips_muldiv_unit.sv
// Iterative radix-2 multiply / restoring divide unit
// with architectural HI/LO for the MIPS EX stage.
module mips_muldiv_unit
  import mips_pkg::*;
#(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  input  logic [1:0]       op,
  input  logic [WIDTH-1:0] rs_data,
  input  logic [WIDTH-1:0] rt_data,
  input  logic             kill,
  input  logic             hi_we,
  input  logic             lo_we,
  input  logic [WIDTH-1:0] wr_data,
  output logic             busy,
  output logic             done,
  output logic             div_by_zero,
  output logic [WIDTH-1:0] hi,
  output logic [WIDTH-1:0] lo
);

  localparam int CW = $clog2(WIDTH) + 1;
  localparam int AW = 2 * WIDTH + 1;
  localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

  logic [1:0]       rsync_q;
  logic             rst_n;

  logic [1:0]       state_q, state_d;
  logic [CW-1:0]    cnt_q, cnt_d;
  logic [AW-1:0]    acc_q, acc_d;
  logic [WIDTH-1:0] b_q, b_d;
  logic             div_q, div_d;
  logic             neg_res_q, neg_res_d;
  logic             neg_rem_q, neg_rem_d;
  logic             dz_q, dz_d;
  logic             done_q, done_d;
  logic             dzf_q, dzf_d;
  logic [WIDTH-1:0] hi_q, hi_d;
  logic [WIDTH-1:0] lo_q, lo_d;

  logic             sgn;
  logic [WIDTH-1:0] abs_a, abs_b;
  logic [WIDTH:0]   mul_sum;
  logic [AW-1:0]    mul_next;
  logic [AW-1:0]    div_sh;
  logic [WIDTH+1:0] trial;
  logic [AW-1:0]    div_next;
  logic [2*WIDTH-1:0] prod_fix;
  logic [WIDTH-1:0] quot_fix, rem_fix;

  // Reset asserts asynchronously, releases on a clock edge
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) rsync_q <= 2'b00;
    else        rsync_q <= {rsync_q[0], 1'b1};
  end

  assign rst_n = rsync_q[1];

  assign sgn = op_is_signed(op);

  cond_negate #(.WIDTH(WIDTH)) u_abs_a (
    .sel (sgn & rs_data[WIDTH-1]),
    .x   (rs_data),
    .y   (abs_a)
  );

  cond_negate #(.WIDTH(WIDTH)) u_abs_b (
    .sel (sgn & rt_data[WIDTH-1]),
    .x   (rt_data),
    .y   (abs_b)
  );

  // One shift-add or restoring-subtract step
  always_comb begin
    mul_sum  = acc_q[AW-1:WIDTH]
             + (acc_q[0] ? {1'b0, b_q} : '0);
    mul_next = {1'b0, mul_sum, acc_q[WIDTH-1:1]};
    div_sh   = {acc_q[AW-2:0], 1'b0};
    trial    = {1'b0, div_sh[AW-1:WIDTH]}
             - {2'b00, b_q};
    div_next = trial[WIDTH+1] ? div_sh :
               {trial[WIDTH:0], div_sh[WIDTH-1:1], 1'b1};
  end

  cond_negate #(.WIDTH(2*WIDTH)) u_fix_p (
    .sel (neg_res_q),
    .x   (acc_q[2*WIDTH-1:0]),
    .y   (prod_fix)
  );

  // Divide-by-zero keeps the raw all-ones quotient
  cond_negate #(.WIDTH(WIDTH)) u_fix_q (
    .sel (neg_res_q & ~dz_q),
    .x   (acc_q[WIDTH-1:0]),
    .y   (quot_fix)
  );

  cond_negate #(.WIDTH(WIDTH)) u_fix_r (
    .sel (neg_rem_q),
    .x   (acc_q[2*WIDTH-1:WIDTH]),
    .y   (rem_fix)
  );

  // FSM, iteration and HI/LO next-state
  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    acc_d     = acc_q;
    b_d       = b_q;
    div_d     = div_q;
    neg_res_d = neg_res_q;
    neg_rem_d = neg_rem_q;
    dz_d      = dz_q;
    done_d    = 1'b0;
    dzf_d     = 1'b0;
    hi_d      = hi_q;
    lo_d      = lo_q;
    case (state_q)
      ST_IDLE: begin
        if (hi_we) hi_d = wr_data;
        if (lo_we) lo_d = wr_data;
        if (start && !kill) begin
          state_d   = ST_CALC;
          cnt_d     = '0;
          acc_d     = {{(WIDTH+1){1'b0}}, abs_a};
          b_d       = abs_b;
          div_d     = op_is_div(op);
          neg_res_d = sgn
                    & (rs_data[WIDTH-1] ^ rt_data[WIDTH-1]);
          neg_rem_d = sgn & op_is_div(op)
                    & rs_data[WIDTH-1];
          dz_d      = op_is_div(op) & (rt_data == '0);
        end
      end
      ST_CALC: begin
        if (kill) begin
          state_d = ST_IDLE;
        end else begin
          acc_d = div_q ? div_next : mul_next;
          cnt_d = cnt_q + CW'(1);
          if (cnt_q == LAST) state_d = ST_FIX;
        end
      end
      ST_FIX: begin
        state_d = ST_IDLE;
        if (!kill) begin
          done_d = 1'b1;
          dzf_d  = dz_q;
          if (div_q) begin
            hi_d = rem_fix;
            lo_d = quot_fix;
          end else begin
            hi_d = prod_fix[2*WIDTH-1:WIDTH];
            lo_d = prod_fix[WIDTH-1:0];
          end
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  // State and architectural register update
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= ST_IDLE;
      cnt_q     <= '0;
      acc_q     <= '0;
      b_q       <= '0;
      div_q     <= 1'b0;
      neg_res_q <= 1'b0;
      neg_rem_q <= 1'b0;
      dz_q      <= 1'b0;
      done_q    <= 1'b0;
      dzf_q     <= 1'b0;
      hi_q      <= '0;
      lo_q      <= '0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      acc_q     <= acc_d;
      b_q       <= b_d;
      div_q     <= div_d;
      neg_res_q <= neg_res_d;
      neg_rem_q <= neg_rem_d;
      dz_q      <= dz_d;
      done_q    <= done_d;
      dzf_q     <= dzf_d;
      hi_q      <= hi_d;
      lo_q      <= lo_d;
    end
  end

  assign busy        = (state_q != ST_IDLE);
  assign done        = done_q;
  assign div_by_zero = dzf_q;
  assign hi          = hi_q;
  assign lo          = lo_q;

endmodule

// File: doc/mips_muldiv_unit.md
# mips_muldiv_unit

Iterative multiply/divide unit with architectural HI/LO registers for the pipelined MIPS core. Executes MULT, MULTU, DIV and DIVU on operand width `WIDTH` using radix-2 shift-add / restoring-divide iterations. It also serves MTHI/MTLO writes and MFHI/MFLO reads. It sits beside the ALU in EX and drives a `busy` stall toward the hazard logic while an operation is in flight.

## Interface
- `WIDTH`, 32: operand width; even, ≥4. HI and LO are each `WIDTH` bits.
- `clk` in 1: single clock; all state changes on the rising edge.
- `reset` in 1: asynchronous, active-low reset.
- `start` in 1: launch the operation in `op` with `rs_data`/`rt_data`; honoured only in IDLE.
- `op` in 2: 00 MULTU, 01 MULT, 10 DIVU, 11 DIV.
- `rs_data` in WIDTH: multiplicand / dividend.
- `rt_data` in WIDTH: multiplier / divisor.
- `kill` in 1: pipeline flush; aborts an in-flight operation.
- `hi_we`, `lo_we` in 1: MTHI / MTLO write strobes; honoured only in IDLE.
- `wr_data` in WIDTH: data for `hi_we`/`lo_we`.
- `busy` out 1: operation in flight; the pipeline stalls MF*/MT*/mul/div while high.
- `done` out 1: one-cycle pulse when HI/LO take the new result.
- `div_by_zero` out 1: pulses with `done` for DIV/DIVU with `rt_data`==0.
- `hi`, `lo` out WIDTH: architectural HI/LO register contents (MFHI/MFLO source).

## Operation
- FSM states: IDLE, CALC, FIX.
  - IDLE: `start` → CALC. Captures operands and op, takes absolute values for signed ops, records result signs, and clears the iteration counter.
  - CALC: one iteration per cycle for exactly `WIDTH` cycles, then → FIX.
  - FIX: applies sign correction, writes HI/LO, pulses `done` → IDLE.
- Multiply: 2·WIDTH product; HI = upper half, LO = lower half.
  - Signed: product negated if operand signs differ.
- Divide: LO = quotient, HI = remainder.
  - Signed: quotient truncated toward zero; remainder takes the dividend's sign.
- Divide by zero: no trap. HI = dividend, LO = all ones. Signed case: LO = all ones (unsigned restoring result, no sign fix), HI = dividend unchanged. `div_by_zero`=1 with `done`.
- Signed overflow (−2^(WIDTH−1) / −1): LO = 2^(WIDTH−1) pattern, HI = 0; no flag.
- `kill` in CALC or FIX: → IDLE next edge; HI/LO unchanged; no `done`.
- `kill` in IDLE: no effect.
- `kill` together with `start` in IDLE: `start` ignored.
- `start` while busy: ignored (no queueing).
- `hi_we`/`lo_we` while busy: ignored.
- `start` and `hi_we`/`lo_we` in the same IDLE cycle: both take effect. MT* writes HI/LO now; the operation's result overwrites at FIX.
- HI/LO only change on MT* writes, at FIX, or on reset.

## Timing
- Reset (async assert, sync release inside the design): state IDLE, `busy`=0, `done`=0, `div_by_zero`=0, `hi`=0, `lo`=0, counter 0.
- Reset asserted mid-operation: immediate return to these values.
- `start` sampled at edge 0:
  - `busy`=1 from after edge 0 through the cycle ending at edge WIDTH+1 (CALC for WIDTH cycles, then FIX).
  - At edge WIDTH+1, HI/LO update, and `done`/`div_by_zero` are registered high for the following cycle, in which `busy`=0.
- Latency start→`done`: WIDTH+1 edges; WIDTH=32 gives 33.
- New `start` is accepted in the same cycle `done` is high.
- MT* write visible on `hi`/`lo` after the next edge. Outputs are registered; no combinational path from inputs to outputs.
- Counter width: $clog2(WIDTH)+1.

## Structure
- Shared package `mips_pkg`: `op` encoding localparams (MULTU/MULT/DIVU/DIV), FSM state encoding.
- One sub-module `cond_negate` (WIDTH-parametrised; output = sel ? −x : x). Used for operand absolute values and result sign fix.
- Datapath: 2·WIDTH+1-bit accumulator/remainder shift register plus WIDTH-bit operand register.

## Test plan
- MULT rs=0xFFFFFFFF, rt=0x00000002 → `done` 33 edges later; HI=0xFFFFFFFF, LO=0xFFFFFFFE. Same operands as MULTU → HI=0x00000001, LO=0xFFFFFFFE.
- DIV rs=0xFFFFFFF9 (−7), rt=2 → LO=0xFFFFFFFD, HI=0xFFFFFFFF. DIVU rs=100, rt=7 → LO=14, HI=2.
- DIVU rs=0x64, rt=0 → HI=0x64, LO=0xFFFFFFFF, `div_by_zero`=1 for exactly one cycle. DIV rs=0x80000000, rt=0xFFFFFFFF → LO=0x80000000, HI=0, `div_by_zero`=0.
- MTHI wr_data=0xA5A5A5A5 in IDLE → `hi`=0xA5A5A5A5 next cycle. Repeat MTHI while busy → `hi` unchanged.
- MULT started, then `kill` at cycle 10 → `busy`=0 next cycle, no `done`, HI/LO keep prior values. Immediate new `start` completes normally.
- Reset pulsed at cycle 20 of a DIV → all outputs 0 asynchronously. After release, `start` MULTU 3×5 → LO=15, HI=0.
